// File: rtl/memwb_fwd_stage.sv
// MEM/WB pipeline register with stall/flush, write-back selection and tagged forwarding history.
// MEMWB_FWD_HIST_EN: when defined, lookups search all HIST_DEPTH entries; otherwise only H[0].
module memwb_fwd_stage #(
    parameter int INSTR_W    = 16,
    parameter int DATA_W     = 16,
    parameter int RESULT_W   = 32,
    parameter int HIST_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [INSTR_W-1:0]  in_instr,
    input  logic [DATA_W-1:0]   in_read_data,
    input  logic [DATA_W-1:0]   in_op1,
    input  logic [RESULT_W-1:0] in_alu_result,
    input  logic                stall,
    input  logic                flush,
    output logic                out_valid,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [DATA_W-1:0]   out_read_data,
    output logic [RESULT_W-1:0] out_alu_result,
    output logic                wb_en,
    output logic [3:0]          wb_reg,
    output logic [RESULT_W-1:0] wb_data,
    output logic [RESULT_W-1:0] fwd_now,
    input  logic [3:0]          q_rs1_addr,
    input  logic [3:0]          q_rs2_addr,
    output logic                q_rs1_hit,
    output logic                q_rs2_hit,
    output logic [RESULT_W-1:0] q_rs1_data,
    output logic [RESULT_W-1:0] q_rs2_data
);

`ifdef MEMWB_FWD_HIST_EN
    localparam int HN = HIST_DEPTH;
`else
    localparam int HN = 1;
`endif

    logic [3:0]          in_opc;
    logic [3:0]          in_rd;
    logic                in_load;
    logic                in_store;
    logic                in_writes;
    logic [RESULT_W-1:0] in_value;
    logic                advance;

    assign in_opc    = in_instr[INSTR_W-1 -: 4];
    assign in_rd     = in_instr[INSTR_W-5 -: 4];
    assign in_load   = (in_opc == 4'b0110) || (in_opc == 4'b0100);
    assign in_store  = (in_opc == 4'b0101) || (in_opc == 4'b0111);
    assign in_writes = in_valid && !in_store;
    assign in_value  = in_load ? RESULT_W'(in_read_data) : in_alu_result;
    assign advance   = !stall || flush;

    always_comb begin
        if (in_load)
            fwd_now = RESULT_W'(in_read_data);
        else if (in_store)
            fwd_now = RESULT_W'(in_op1);
        else
            fwd_now = in_alu_result;
    end

    logic [HN-1:0]       h_valid_q;
    logic [HN-1:0]       h_writes_q;
    logic [3:0]          h_rd_q    [HN];
    logic [RESULT_W-1:0] h_value_q [HN];
    logic [INSTR_W-1:0]  instr_q;
    logic [DATA_W-1:0]   read_data_q;
    logic [RESULT_W-1:0] alu_result_q;

    logic                h0_valid_d;
    logic                h0_writes_d;
    logic [3:0]          h0_rd_d;
    logic [RESULT_W-1:0] h0_value_d;
    logic [INSTR_W-1:0]  instr_d;
    logic [DATA_W-1:0]   read_data_d;
    logic [RESULT_W-1:0] alu_result_d;

    // A flush captures a bubble with every data field zeroed, not just valid.
    always_comb begin
        h0_valid_d   = in_valid;
        h0_writes_d  = in_writes;
        h0_rd_d      = in_rd;
        h0_value_d   = in_value;
        instr_d      = in_instr;
        read_data_d  = in_read_data;
        alu_result_d = in_alu_result;
        if (flush) begin
            h0_valid_d   = 1'b0;
            h0_writes_d  = 1'b0;
            h0_rd_d      = '0;
            h0_value_d   = '0;
            instr_d      = '0;
            read_data_d  = '0;
            alu_result_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_valid_q    <= '0;
            h_writes_q   <= '0;
            instr_q      <= '0;
            read_data_q  <= '0;
            alu_result_q <= '0;
            for (int k = 0; k < HN; k++) begin
                h_rd_q[k]    <= '0;
                h_value_q[k] <= '0;
            end
        end else if (advance) begin
            h_valid_q[0]  <= h0_valid_d;
            h_writes_q[0] <= h0_writes_d;
            h_rd_q[0]     <= h0_rd_d;
            h_value_q[0]  <= h0_value_d;
            instr_q       <= instr_d;
            read_data_q   <= read_data_d;
            alu_result_q  <= alu_result_d;
            for (int k = 1; k < HN; k++) begin
                h_valid_q[k]  <= h_valid_q[k-1];
                h_writes_q[k] <= h_writes_q[k-1];
                h_rd_q[k]     <= h_rd_q[k-1];
                h_value_q[k]  <= h_value_q[k-1];
            end
        end
    end

    assign out_valid      = h_valid_q[0];
    assign out_instr      = instr_q;
    assign out_read_data  = read_data_q;
    assign out_alu_result = alu_result_q;
    assign wb_en          = h_valid_q[0] && h_writes_q[0];
    assign wb_reg         = h_rd_q[0];
    assign wb_data        = h_value_q[0];

    // Scan oldest to youngest so a younger match overwrites any older one.
    function automatic logic [RESULT_W:0] lookup(input logic [3:0] tag);
        logic                hit;
        logic [RESULT_W-1:0] data;
        hit  = 1'b0;
        data = '0;
        for (int k = HN - 1; k >= 0; k--) begin
            if (h_valid_q[k] && h_writes_q[k] && (h_rd_q[k] == tag)) begin
                hit  = 1'b1;
                data = h_value_q[k];
            end
        end
        if (in_writes && (in_rd == tag)) begin
            hit  = 1'b1;
            data = in_value;
        end
        return {hit, data};
    endfunction

    assign {q_rs1_hit, q_rs1_data} = lookup(q_rs1_addr);
    assign {q_rs2_hit, q_rs2_data} = lookup(q_rs2_addr);

endmodule

// File: tb/tb_memwb_fwd_stage.sv
// Randomised and directed bench for memwb_fwd_stage against a queue-style history model.
module tb_memwb_fwd_stage;
    localparam int IW = 16;
    localparam int DW = 16;
    localparam int RW = 32;
    localparam int HD = 2;
`ifdef MEMWB_FWD_HIST_EN
    localparam int DEFF = HD;
`else
    localparam int DEFF = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [IW-1:0] in_instr;
    logic [DW-1:0] in_read_data;
    logic [DW-1:0] in_op1;
    logic [RW-1:0] in_alu_result;
    logic          stall;
    logic          flush;
    logic          out_valid;
    logic [IW-1:0] out_instr;
    logic [DW-1:0] out_read_data;
    logic [RW-1:0] out_alu_result;
    logic          wb_en;
    logic [3:0]    wb_reg;
    logic [RW-1:0] wb_data;
    logic [RW-1:0] fwd_now;
    logic [3:0]    q_rs1_addr;
    logic [3:0]    q_rs2_addr;
    logic          q_rs1_hit;
    logic          q_rs2_hit;
    logic [RW-1:0] q_rs1_data;
    logic [RW-1:0] q_rs2_data;

    always #5 clk = ~clk;

    memwb_fwd_stage #(.INSTR_W(IW), .DATA_W(DW), .RESULT_W(RW), .HIST_DEPTH(HD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
        .in_read_data(in_read_data), .in_op1(in_op1), .in_alu_result(in_alu_result),
        .stall(stall), .flush(flush), .out_valid(out_valid), .out_instr(out_instr),
        .out_read_data(out_read_data), .out_alu_result(out_alu_result),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .fwd_now(fwd_now),
        .q_rs1_addr(q_rs1_addr), .q_rs2_addr(q_rs2_addr),
        .q_rs1_hit(q_rs1_hit), .q_rs2_hit(q_rs2_hit),
        .q_rs1_data(q_rs1_data), .q_rs2_data(q_rs2_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit          v;
        bit          w;
        bit [3:0]    rd;
        bit [RW-1:0] val;
        bit [IW-1:0] instr;
        bit [DW-1:0] rdat;
        bit [RW-1:0] alu;
    } ent_t;

    ent_t hist[HD];

    function automatic bit [3:0] opc_of(input bit [IW-1:0] i);
        return i[IW-1 -: 4];
    endfunction

    function automatic bit [3:0] rd_of(input bit [IW-1:0] i);
        return i[IW-5 -: 4];
    endfunction

    function automatic bit is_load(input bit [IW-1:0] i);
        return opc_of(i) == 4'd6 || opc_of(i) == 4'd4;
    endfunction

    function automatic bit is_store(input bit [IW-1:0] i);
        return opc_of(i) == 4'd5 || opc_of(i) == 4'd7;
    endfunction

    function automatic bit [RW-1:0] zext(input bit [DW-1:0] x);
        bit [RW-1:0] r;
        r = '0;
        r[DW-1:0] = x;
        return r;
    endfunction

    function automatic bit [IW-1:0] mk(input bit [3:0] op, input bit [3:0] rd, input bit [7:0] lo);
        return {op, rd, lo};
    endfunction

    task automatic model_lookup(input bit [3:0] tag, output bit hit, output bit [RW-1:0] d);
        hit = 0;
        d   = '0;
        if (in_valid && !is_store(in_instr) && rd_of(in_instr) == tag) begin
            hit = 1;
            d   = is_load(in_instr) ? zext(in_read_data) : in_alu_result;
        end
        for (int k = 0; k < DEFF; k++) begin
            if (!hit && hist[k].v && hist[k].w && hist[k].rd == tag) begin
                hit = 1;
                d   = hist[k].val;
            end
        end
    endtask

    task automatic check_all();
        bit          h;
        bit [RW-1:0] d;
        bit [RW-1:0] f;
        f = is_load(in_instr) ? zext(in_read_data) :
            is_store(in_instr) ? zext(in_op1) : in_alu_result;
        check("fwd_now", fwd_now, f);
        check("out_valid", out_valid, hist[0].v);
        check("out_instr", out_instr, hist[0].instr);
        check("out_read_data", out_read_data, hist[0].rdat);
        check("out_alu_result", out_alu_result, hist[0].alu);
        check("wb_en", wb_en, hist[0].v && hist[0].w);
        check("wb_reg", wb_reg, hist[0].rd);
        check("wb_data", wb_data, hist[0].val);
        model_lookup(q_rs1_addr, h, d);
        check("q_rs1_hit", q_rs1_hit, h);
        check("q_rs1_data", q_rs1_data, d);
        model_lookup(q_rs2_addr, h, d);
        check("q_rs2_hit", q_rs2_hit, h);
        check("q_rs2_data", q_rs2_data, d);
    endtask

    task automatic apply(input bit v, input bit [IW-1:0] ins, input bit [DW-1:0] rdat,
                         input bit [DW-1:0] op1, input bit [RW-1:0] alu, input bit st,
                         input bit fl, input bit r, input bit [3:0] a1, input bit [3:0] a2,
                         input bit do_chk);
        @(negedge clk);
        in_valid      = v;
        in_instr      = ins;
        in_read_data  = rdat;
        in_op1        = op1;
        in_alu_result = alu;
        stall         = st;
        flush         = fl;
        rst           = r;
        q_rs1_addr    = a1;
        q_rs2_addr    = a2;
        #1;
        if (do_chk) check_all();
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < HD; k++) hist[k] = '{default: 0};
        end else if (flush || !stall) begin
            for (int k = HD - 1; k >= 1; k--) hist[k] = hist[k-1];
            hist[0] = '{default: 0};
            if (!flush) begin
                hist[0].v     = in_valid;
                hist[0].w     = in_valid && !is_store(in_instr);
                hist[0].rd    = rd_of(in_instr);
                hist[0].val   = is_load(in_instr) ? zext(in_read_data) : in_alu_result;
                hist[0].instr = in_instr;
                hist[0].rdat  = in_read_data;
                hist[0].alu   = in_alu_result;
            end
        end
    endtask

    task automatic idle(input bit [3:0] a1, input bit [3:0] a2);
        apply(0, mk(4'd1, 4'd0, 8'd0), '0, '0, '0, 0, 0, 0, a1, a2, 1);
    endtask

    initial begin
        for (int k = 0; k < HD; k++) hist[k] = '{default: 0};

        // Reset held two cycles with a valid writer on the input
        apply(1, mk(4'd1, 4'd2, 8'h11), 16'h1111, 16'h2222, 32'h33, 0, 0, 1, 4'd2, 4'd3, 0);
        adv();
        apply(1, mk(4'd1, 4'd2, 8'h11), 16'h1111, 16'h2222, 32'h33, 0, 0, 1, 4'd2, 4'd3, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_incoming_hit", q_rs1_hit, 1);
        check("rst_other_hit", q_rs2_hit, 0);
        adv();

        // Load
        apply(1, mk(4'd6, 4'd3, 8'h00), 16'hBEEF, 16'h0000, 32'h1234, 0, 0, 0, 4'd3, 4'd4, 1);
        check("ld_fwd_now", fwd_now, 32'h0000BEEF);
        adv();
        idle(4'd3, 4'd4);
        check("ld_wb_en", wb_en, 1);
        check("ld_wb_reg", wb_reg, 3);
        check("ld_wb_data", wb_data, 32'h0000BEEF);
        adv();

        // Store
        apply(1, mk(4'd5, 4'd4, 8'h00), 16'h1234, 16'h00AA, 32'h99, 0, 0, 0, 4'd4, 4'd4, 1);
        check("st_fwd_now", fwd_now, 32'h000000AA);
        check("st_in_miss", q_rs1_hit, 0);
        adv();
        idle(4'd4, 4'd4);
        check("st_wb_en", wb_en, 0);
        check("st_h0_miss", q_rs1_hit, 0);
        adv();

        // History priority on rd=5
        for (int i = 1; i <= 3; i++) begin
            apply(1, mk(4'd1, 4'd5, 8'd0), '0, '0, RW'(i), 0, 0, 0, 4'd5, 4'd5, 1);
            check("hist_incoming", q_rs1_data, RW'(i));
            adv();
        end
        idle(4'd5, 4'd5);
        check("hist_h0_data", q_rs1_data, 3);
        adv();
        idle(4'd5, 4'd5);
        check("hist_h1_hit", q_rs1_hit, DEFF >= 2);
        adv();
        idle(4'd5, 4'd5);
        check("hist_aged_out", q_rs1_hit, 0);
        adv();

        // Stall freezes state
        apply(1, mk(4'd2, 4'd9, 8'd0), '0, '0, 32'h55, 0, 0, 0, 4'd9, 4'd9, 1);
        adv();
        for (int i = 0; i < 3; i++) begin
            apply(1, mk(4'd2, 4'd10, 8'(i)), '0, '0, RW'(100 + i), 1, 0, 0, 4'd9, 4'd10, 1);
            check("stall_alu_frozen", out_alu_result, 32'h55);
            check("stall_hit_frozen", q_rs1_hit, 1);
            adv();
        end
        // Flush while stalled
        apply(1, mk(4'd2, 4'd11, 8'd0), '0, '0, 32'h77, 1, 1, 0, 4'd9, 4'd11, 1);
        adv();
        idle(4'd9, 4'd11);
        check("flush_out_valid", out_valid, 0);
        check("flush_shift_hit", q_rs1_hit, DEFF >= 2);
        check("flush_bubble_miss", q_rs2_hit, 0);
        adv();

        // Two-instructions-ago lookup depends on the history macro
        apply(1, mk(4'd1, 4'd7, 8'd0), '0, '0, 32'h7777, 0, 0, 0, 4'd7, 4'd1, 1);
        adv();
        apply(1, mk(4'd1, 4'd1, 8'd0), '0, '0, 32'h1, 0, 0, 0, 4'd7, 4'd1, 1);
        adv();
        idle(4'd7, 4'd1);
        check("macro_h1_hit", q_rs1_hit, DEFF >= 2);
        adv();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit [3:0] op;
            op = 4'($urandom_range(0, 15));
            apply(1'($urandom_range(0, 3) != 0),
                  mk(op, 4'($urandom_range(0, 7)), 8'($urandom)),
                  DW'($urandom), DW'($urandom), RW'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 49) == 0,
                  4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 1);
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
